// File: rtl/data_memory_responder.sv
// Word-organised data RAM answering one LOAD/STORE at a time; ready pulses LATENCY+1 cycles after the request is seen.
// No backpressure: the initiator holds read/write until ready, and requests are only sampled in IDLE.
module data_memory_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_memory_a,
    input  logic [31:0] data_memory_out_v,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    output logic [31:0] data_memory_in_v,
    output logic        data_memory_ready,
    output logic        data_memory_busy,
    output logic        data_memory_fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_latch;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]      w_offset;
    logic [29:0]      w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_legal;
    logic             w_conflict;
    logic             w_do_access;
    logic             w_mem_we;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_word      = w_offset[31:2];
    assign w_idx       = w_word[IDX_W-1:0];
    assign w_legal     = (w_offset[1:0] == 2'b00) && (w_word < 30'(DEPTH_WORDS));
    assign w_conflict  = r_rd && r_wr;
    assign w_do_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_mem_we    = w_do_access && r_wr && !r_rd && w_legal;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_memory_read || data_memory_write) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = 4'(LATENCY - 1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= data_memory_a;
                r_wdata <= data_memory_out_v;
                r_rd    <= data_memory_read;
                r_wr    <= data_memory_write;
            end
        end
    end

    // Read data and fault change only on the WAIT-to-RESP edge; a conflict leaves read data untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else if (w_do_access) begin
            r_fault <= w_conflict || !w_legal;
            if (!w_conflict && r_rd) begin
                r_rdata <= w_legal ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // RAM has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign data_memory_in_v  = r_rdata;
    assign data_memory_ready = (r_state == S_RESP);
    assign data_memory_busy  = (r_state != S_IDLE);
    assign data_memory_fault = r_fault;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with default parameters (LATENCY=2, DEPTH_WORDS=1024, BASE_ADDR=0).
module tb_data_memory_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] wd;
    logic        read;
    logic        write;
    logic [31:0] in_v;
    logic        ready;
    logic        busy;
    logic        fault;

    int          vectors;
    int          errors;
    logic [31:0] g_data;
    logic        g_fault;
    logic [15:0] g_bhist;

    data_memory_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .data_memory_a     (a),
        .data_memory_out_v (wd),
        .data_memory_read  (read),
        .data_memory_write (write),
        .data_memory_in_v  (in_v),
        .data_memory_ready (ready),
        .data_memory_busy  (busy),
        .data_memory_fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge following ready with the request dropped.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] d, input string tag);
        int          lat;
        logic [15:0] bh;
        lat   = 99;
        bh    = 16'd0;
        read  = rd;
        write = wr;
        a     = addr;
        wd    = d;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            bh[n] = busy;
            if (ready) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        g_data  = in_v;
        g_fault = fault;
        g_bhist = bh;
        check({tag, "_latency"}, 32'(lat), 32'd3);
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int          lat2;
        logic        seen_ready;
        logic [15:0] bh2;

        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        a       = 32'd0;
        wd      = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_v",  in_v,  32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
        check("wr10_busy_hist", 32'(g_bhist[3:0]), 32'h0000_000E);
        check("wr10_fault", 32'(g_fault), 32'd0);
        check("wr10_in_v",  g_data, 32'd0);
        @(negedge clk);
        check("wr10_ready_drop", 32'(ready), 32'd0);
        check("wr10_busy_drop",  32'(busy),  32'd0);
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, "rd10");
        check("rd10_data",  g_data, 32'hDEAD_BEEF);
        check("rd10_fault", 32'(g_fault), 32'd0);
        @(negedge clk);
        check("rd10_held", in_v, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 32'h0000_0012, 32'd0, "rd_misal");
        check("rd_misal_fault", 32'(g_fault), 32'd1);
        check("rd_misal_data",  g_data, 32'd0);

        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, "rd10b");
        check("rd10b_data", g_data, 32'hDEAD_BEEF);

        access(1'b1, 1'b0, 32'h0000_1000, 32'd0, "rd_oor");
        check("rd_oor_fault", 32'(g_fault), 32'd1);
        check("rd_oor_data",  g_data, 32'd0);

        access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, "wr20");
        access(1'b1, 1'b0, 32'h0000_0010, 32'd0, "rd10c");
        access(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, "conflict");
        check("conflict_fault", 32'(g_fault), 32'd1);
        check("conflict_data",  g_data, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0020, 32'd0, "rd20");
        check("rd20_data",  g_data, 32'hCAFE_0020);
        check("rd20_fault", 32'(g_fault), 32'd0);

        access(1'b0, 1'b1, 32'h0000_0040, 32'h5555_0040, "wr40");
        access(1'b1, 1'b0, 32'h0000_0040, 32'd0, "rd40");
        check("rd40_data", g_data, 32'h5555_0040);

        // Abort a write in WAIT with an asynchronous reset.
        write = 1'b1;
        a     = 32'h0000_0040;
        wd    = 32'hAAAA_AAAA;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_wait", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_in_v",  in_v, 32'd0);
        write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        seen_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            seen_ready = seen_ready | ready;
        end
        check("abort_no_ready", 32'(seen_ready), 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h0000_0040, 32'd0, "rd40_after");
        check("rd40_after_data", g_data, 32'h5555_0040);

        // Inputs changed during WAIT are ignored; request then held one cycle past ready.
        write = 1'b1;
        read  = 1'b0;
        a     = 32'h0000_0004;
        wd    = 32'h0BAD_0004;
        @(posedge clk);
        #1;
        a  = 32'h0000_0008;
        wd = 32'hFFFF_FFFF;
        lat2 = 99;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (ready) begin
                lat2 = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("hold_first_latency", 32'(lat2), 32'd2);
        @(posedge clk);
        #1;
        lat2 = 99;
        bh2  = 16'd0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            bh2[n] = busy;
            if (ready) begin
                lat2 = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("hold_idle_busy", 32'(bh2[0]), 32'd0);
        check("hold_second_latency", 32'(lat2), 32'd3);
        @(posedge clk);
        #1;
        write = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0004, 32'd0, "rd04");
        check("rd04_data", g_data, 32'h0BAD_0004);
        access(1'b1, 1'b0, 32'h0000_0008, 32'd0, "rd08");
        check("rd08_data", g_data, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
